tt_um_adennen_inv_array: RTL and testbench



---
 rtl/tt_inv_pkg.sv | 26 ++
 rtl/tt_um_adennen_inv_array_sync_edge.sv | 45 ++++
 rtl/tt_um_adennen_inv_array.sv | 164 ++++++++++++++++
 tb/tb_tt_um_adennen_inv_array.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/tt_inv_pkg.sv
// Shared types and constants for the programmable inverter array tile.
package tt_inv_pkg;

   // Edge counter width; readout is exactly two bytes.
   localparam int CNT_W = 16;

   // Measurement sequencer states.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARM   = 2'd1,
      COUNT = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Output byte selection codes on uio_in[6:5].
   localparam logic [1:0] OSEL_DATA   = 2'b00;
   localparam logic [1:0] OSEL_CNT_LO = 2'b01;
   localparam logic [1:0] OSEL_CNT_HI = 2'b10;
   localparam logic [1:0] OSEL_STATUS = 2'b11;

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/tt_um_adennen_inv_array_sync_edge.sv
// Multi-bit input synchroniser with an optional rising-edge detector.
// Each bit is synchronised independently; no bus coherence is implied.
module sync_edge #(
   parameter int W      = 1,
   parameter int STAGES = 2,
   parameter bit EDGE   = 1'b0
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic [W-1:0] i_d,
   output logic [W-1:0] o_q,
   output logic [W-1:0] o_rise
);

   logic [W-1:0] r_stg [STAGES];

   // Shift the raw inputs through the flop chain.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int k = 0; k < STAGES; k++) r_stg[k] <= '0;
      end else begin
         r_stg[0] <= i_d;
         for (int k = 1; k < STAGES; k++) r_stg[k] <= r_stg[k-1];
      end
   end

   assign o_q = r_stg[STAGES-1];

   generate
      if (EDGE) begin : g_edge
         logic [W-1:0] r_prev;

         // Remember last synchronised value for rising-edge detection.
         always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) r_prev <= '0;
            else          r_prev <= o_q;
         end

         assign o_rise = o_q & ~r_prev;
      end else begin : g_no_edge
         assign o_rise = '0;
      end
   endgenerate

endmodule

// File: rtl/tt_um_adennen_inv_array.sv
// TinyTapeout tile: per-channel programmable inverters plus a gated
// toggle counter on one selectable channel for on-silicon checking.
module tt_um_adennen_inv_array
   import tt_inv_pkg::*;
#(
   parameter int CHANNELS    = 8,
   parameter int SYNC_STAGES = 2,
   parameter int GATE_CYCLES = 1000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   output logic [7:0] uo_out,
   input  logic [7:0] uio_in,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   localparam int GATE_W = $clog2(GATE_CYCLES + 1);
   localparam logic [GATE_W-1:0] GATE_LOAD = GATE_W'(GATE_CYCLES);
   localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(1);

   logic [CHANNELS-1:0] w_ch_sync;
   logic [CHANNELS-1:0] w_ch_rise_nc;
   logic [6:0]          w_ctl_sync;
   logic [6:0]          w_ctl_rise;
   logic                w_cfg_rise;
   logic                w_start_rise;
   logic [2:0]          w_ch_sel;
   logic [1:0]          w_out_sel;
   logic [7:0]          w_ch_pad;
   logic [7:0]          w_out_pad;
   logic                w_sample;
   logic                w_busy;

   logic [CHANNELS-1:0] r_inv_mask;
   logic [CHANNELS-1:0] r_out_q;
   state_t              r_state;
   logic [2:0]          r_ch_q;
   logic                r_prev;
   logic [GATE_W-1:0]   r_gate;
   logic [CNT_W-1:0]    r_count;
   logic                r_done;
   logic                r_sat;

   sync_edge #(
      .W      (CHANNELS),
      .STAGES (SYNC_STAGES),
      .EDGE   (1'b0)
   ) u_sync_ch (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_d     (ui_in[CHANNELS-1:0]),
      .o_q     (w_ch_sync),
      .o_rise  (w_ch_rise_nc)
   );

   sync_edge #(
      .W      (7),
      .STAGES (SYNC_STAGES),
      .EDGE   (1'b1)
   ) u_sync_ctl (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_d     (uio_in[6:0]),
      .o_q     (w_ctl_sync),
      .o_rise  (w_ctl_rise)
   );

   assign w_cfg_rise   = w_ctl_rise[0];
   assign w_start_rise = w_ctl_rise[1];
   assign w_ch_sel     = w_ctl_sync[4:2];
   assign w_out_sel    = w_ctl_sync[6:5];
   assign w_busy       = (r_state == ARM) || (r_state == COUNT);

   // Zero-extend channel vectors to a full byte; absent channels read as 0.
   always_comb begin
      w_ch_pad                 = '0;
      w_ch_pad[CHANNELS-1:0]   = w_ch_sync;
      w_out_pad                = '0;
      w_out_pad[CHANNELS-1:0]  = r_out_q;
   end

   // Counter taps the synchronised input ahead of the mask, so mask
   // reloads never disturb a running measurement.
   assign w_sample = w_ch_pad[r_ch_q];

   // Invert mask, reloaded from the data pins on a cfg_wr rising edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)          r_inv_mask <= '1;
      else if (w_cfg_rise) r_inv_mask <= w_ch_sync;
   end

   // Registered inverter datapath.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_out_q <= '0;
      else        r_out_q <= w_ch_sync ^ r_inv_mask;
   end

   // Measurement sequencer: arm, count toggles over the gate, hold result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_ch_q  <= '0;
         r_prev  <= 1'b0;
         r_gate  <= '0;
         r_count <= '0;
         r_done  <= 1'b0;
         r_sat   <= 1'b0;
      end else begin
         case (r_state)
            IDLE, DONE: begin
               if (w_start_rise) begin
                  r_state <= ARM;
                  r_ch_q  <= w_ch_sel;
                  r_count <= '0;
                  r_done  <= 1'b0;
                  r_sat   <= 1'b0;
               end
            end
            ARM: begin
               r_prev  <= w_sample;
               r_gate  <= GATE_LOAD;
               r_state <= COUNT;
            end
            COUNT: begin
               if (w_sample != r_prev) begin
                  r_count <= sat_inc(r_count);
                  if (sat_inc(r_count) == {CNT_W{1'b1}}) r_sat <= 1'b1;
               end
               r_prev <= w_sample;
               r_gate <= r_gate - 1'b1;
               if (r_gate == GATE_LAST) begin
                  r_state <= DONE;
                  r_done  <= 1'b1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // Output byte selection.
   always_comb begin
      uo_out = '0;
      case (w_out_sel)
         OSEL_DATA:   uo_out = w_out_pad;
         OSEL_CNT_LO: uo_out = r_count[7:0];
         OSEL_CNT_HI: uo_out = r_count[15:8];
         OSEL_STATUS: uo_out = {w_busy, r_done, r_sat, 2'b00, r_ch_q};
         default:     uo_out = '0;
      endcase
   end

   assign uio_out = '0;
   assign uio_oe  = '0;

   // Inputs intentionally left without a function in this tile.
   logic w_unused_ok;
   assign w_unused_ok = &{1'b0, ena, ui_in, uio_in[7], w_ch_rise_nc,
                          w_ctl_rise[6:2], w_ctl_sync[1:0]};

endmodule

// File: tb/tb_tt_um_adennen_inv_array.sv
// Directed bench for the inverter array tile: three instances cover the
// main configuration, a saturating long gate and a 4-channel build.
module tb_tt_um_adennen_inv_array;

   logic clk = 1'b0;
   logic rst_n;
   logic rst_s_n;
   logic tog;
   logic [7:0] ui_a, uio_a, ui_c, uio_c, uio_s;
   logic [7:0] ui_s;
   logic [7:0] uo_a, uo_c, uo_s;
   logic [7:0] uioo_a, uioe_a, uioo_c, uioe_c, uioo_s, uioe_s;
   logic [7:0] v;
   int n_vec = 0;
   int n_err = 0;
   int per_a = 0, cnt_a = 0, per_c = 0, cnt_c = 0;
   int cyc;

   assign ui_s = {7'b0, tog};

   always #5 clk = ~clk;

   tt_um_adennen_inv_array #(.CHANNELS(8), .SYNC_STAGES(2), .GATE_CYCLES(100)) dut_a (
      .clk(clk), .rst_n(rst_n), .ena(1'b1), .ui_in(ui_a), .uo_out(uo_a),
      .uio_in(uio_a), .uio_out(uioo_a), .uio_oe(uioe_a));

   tt_um_adennen_inv_array #(.CHANNELS(8), .SYNC_STAGES(2), .GATE_CYCLES(65600)) dut_s (
      .clk(clk), .rst_n(rst_s_n), .ena(1'b1), .ui_in(ui_s), .uo_out(uo_s),
      .uio_in(uio_s), .uio_out(uioo_s), .uio_oe(uioe_s));

   tt_um_adennen_inv_array #(.CHANNELS(4), .SYNC_STAGES(2), .GATE_CYCLES(20)) dut_c (
      .clk(clk), .rst_n(rst_n), .ena(1'b1), .ui_in(ui_c), .uo_out(uo_c),
      .uio_in(uio_c), .uio_out(uioo_c), .uio_oe(uioe_c));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic chk_rng(input string tag, input logic [7:0] got, input int lo, input int hi);
      n_vec++;
      assert (!$isunknown(got) && int'(got) >= lo && int'(got) <= hi) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d..%0d", tag, got, lo, hi);
      end
   endtask

   // One clock: advance past the edge, then update free-running toggles.
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         tog = ~tog;
         if (per_a > 0) begin
            cnt_a++;
            if (cnt_a >= per_a) begin cnt_a = 0; ui_a[3] = ~ui_a[3]; end
         end
         if (per_c > 0) begin
            cnt_c++;
            if (cnt_c >= per_c) begin cnt_c = 0; ui_c = ~ui_c; end
         end
      end
   endtask

   task automatic rd_a(input logic [1:0] sel, output logic [7:0] val);
      uio_a[6:5] = sel;
      step(3);
      val = uo_a;
   endtask

   initial begin
      rst_n = 1'b0; rst_s_n = 1'b0; tog = 1'b0;
      ui_a = 8'h00; uio_a = 8'h00; ui_c = 8'h00; uio_c = 8'h00; uio_s = 8'h00;
      step(3);
      chk("rst_uo_a", uo_a, 8'h00);
      chk("rst_uo_s", uo_s, 8'h00);
      chk("rst_uo_c", uo_c, 8'h00);
      rst_n = 1'b1; rst_s_n = 1'b1;

      // Long saturating measurement on dut_s runs behind the other tests.
      uio_s = 8'h62;
      step(3);
      chk("t1_flush_ff", uo_a, 8'hFF);
      chk("uio_zero", {uioo_a | uioe_a | uioo_c | uioe_c | uioo_s | uioe_s}, 8'h00);
      chk("c4_data_pad", uo_c, 8'h0F);
      step(1);
      uio_s[1] = 1'b0;

      // Latency of the inverter path.
      ui_a = 8'hA5;
      step(2);
      chk("t1_lat_before", uo_a, 8'hFF);
      step(1);
      chk("t1_lat_at", uo_a, 8'h5A);

      // Mask load.
      ui_a = 8'h0F; uio_a[0] = 1'b1;
      step(3);
      uio_a[0] = 1'b0; ui_a = 8'h00;
      step(3);
      chk("t2_mask_00", uo_a, 8'h0F);
      ui_a = 8'hFF;
      step(3);
      chk("t2_mask_ff", uo_a, 8'hF0);

      // Gated count on channel 3, toggling every 5 cycles.
      ui_a = 8'h00; uio_a[4:2] = 3'd3; uio_a[6:5] = 2'b11;
      step(4);
      cnt_a = 0; per_a = 5; uio_a[1] = 1'b1;
      step(4);
      uio_a[1] = 1'b0;
      step(46);
      chk("t3_busy", uo_a, 8'h83);
      cyc = 50;
      while (uo_a[6] !== 1'b1 && cyc < 300) begin step(1); cyc++; end
      chk("t3_done_cyc", cyc, 104);
      per_a = 0;
      chk("t3_status", uo_a, 8'h43);
      rd_a(2'b01, v); chk_rng("t3_cnt_lo", v, 19, 21);
      rd_a(2'b10, v); chk("t3_cnt_hi", v, 8'h00);

      // Start pulse mid-window must not restart or stretch the gate.
      uio_a[6:5] = 2'b11;
      step(3);
      cnt_a = 0; per_a = 5; uio_a[1] = 1'b1;
      step(4);
      uio_a[1] = 1'b0;
      step(30);
      uio_a[1] = 1'b1;
      step(5);
      uio_a[1] = 1'b0;
      cyc = 39;
      while (uo_a[6] !== 1'b1 && cyc < 300) begin step(1); cyc++; end
      chk("t5_done_cyc", cyc, 104);
      per_a = 0;
      chk("t5_status", uo_a, 8'h43);
      rd_a(2'b01, v); chk_rng("t5_cnt_lo", v, 19, 21);

      // Channel select beyond CHANNELS samples a constant zero.
      uio_c[4:2] = 3'd7; uio_c[6:5] = 2'b11;
      step(3);
      cnt_c = 0; per_c = 3; uio_c[1] = 1'b1;
      step(4);
      uio_c[1] = 1'b0;
      cyc = 4;
      while (uo_c[6] !== 1'b1 && cyc < 300) begin step(1); cyc++; end
      chk("t5c_done_cyc", cyc, 24);
      per_c = 0;
      chk("t5c_status", uo_c, 8'h47);
      uio_c[6:5] = 2'b01; step(3);
      chk("t5c_cnt_lo", uo_c, 8'h00);
      uio_c[6:5] = 2'b10; step(3);
      chk("t5c_cnt_hi", uo_c, 8'h00);

      // Asynchronous reset in the middle of a measurement.
      uio_a[6:5] = 2'b11; uio_a[4:2] = 3'd3;
      step(3);
      cnt_a = 0; per_a = 5; uio_a[1] = 1'b1;
      step(4);
      uio_a[1] = 1'b0;
      step(26);
      chk("t6_busy_pre", uo_a[7], 1'b1);
      rst_n = 1'b0;
      #1;
      chk("t6_rst_uo", uo_a, 8'h00);
      per_a = 0; ui_a = 8'h00;
      step(2);
      rst_n = 1'b1;
      step(3);
      chk("t6_status", uo_a, 8'h00);
      rd_a(2'b01, v); chk("t6_cnt_lo", v, 8'h00);
      rd_a(2'b10, v); chk("t6_cnt_hi", v, 8'h00);
      rd_a(2'b00, v); chk("t6_mask_ff", v, 8'hFF);
      uio_a[6:5] = 2'b11; uio_a[4:2] = 3'd3;
      step(3);
      cnt_a = 0; per_a = 5; uio_a[1] = 1'b1;
      step(4);
      uio_a[1] = 1'b0;
      cyc = 4;
      while (uo_a[6] !== 1'b1 && cyc < 300) begin step(1); cyc++; end
      chk("t6_done_cyc", cyc, 104);
      per_a = 0;
      rd_a(2'b01, v); chk_rng("t6_cnt_lo", v, 19, 21);

      // Saturation result from the long-gate instance.
      cyc = 0;
      while (uo_s[6] !== 1'b1 && cyc < 70000) begin step(1); cyc++; end
      chk("t4_done", uo_s[6], 1'b1);
      chk("t4_status", uo_s, 8'h60);
      uio_s[6:5] = 2'b01; step(3);
      chk("t4_cnt_lo", uo_s, 8'hFF);
      uio_s[6:5] = 2'b10; step(3);
      chk("t4_cnt_hi", uo_s, 8'hFF);
      step(40);
      chk("t4_hold_hi", uo_s, 8'hFF);
      uio_s[6:5] = 2'b11; step(3);
      chk("t4_hold_status", uo_s, 8'h60);
      uio_s[1] = 1'b1;
      step(6);
      chk("t4_restart", uo_s, 8'h80);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
